// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MMIO offsets and byte-lane helpers for the data memory
package dmem_pkg;

    // Byte offsets inside the 16-byte MMIO window
    localparam logic [31:0] MMIO_CNT_LO = 32'h0;
    localparam logic [31:0] MMIO_CNT_HI = 32'h4;
    localparam logic [31:0] MMIO_TOHOST = 32'h8;
    localparam logic [31:0] MMIO_SIZE   = 32'h10;

    // Expand four byte enables into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - data-port bus between the core memory stage and the data memory
interface dmem_if;

    logic        mem_d_we;
    logic [3:0]  mem_d_wdbe;
    logic [31:0] mem_d_wa;
    logic [31:0] mem_d_wd;
    logic [31:0] mem_d_rd;

    // Core side drives address/data/enables and samples read data
    modport master (
        output mem_d_we,
        output mem_d_wdbe,
        output mem_d_wa,
        output mem_d_wd,
        input  mem_d_rd
    );

    // Memory side
    modport slave (
        input  mem_d_we,
        input  mem_d_wdbe,
        input  mem_d_wa,
        input  mem_d_wd,
        output mem_d_rd
    );

endinterface

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - word RAM with asynchronous read and byte-enabled clocked write
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wd_i,
    output logic [31:0]                    rd_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] mask;

    assign mask = lane_mask(be_i);

    // Read is combinational, so a same-cycle write is seen only after the edge
    assign rd_o = mem_q[addr_i];

    // Merge enabled lanes into the addressed word; contents are never reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~mask) | (wd_i & mask);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory target: decode, RAM, sticky write error, optional MMIO (DMEM_MMIO_EN)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    dmem_if.slave       bus,
    output logic        err,
`ifdef DMEM_MMIO_EN
    output logic [31:0] err_addr,
    output logic [31:0] tohost
`else
    output logic [31:0] err_addr
`endif
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_LO  = {1'b0, BASE_ADDR};
    localparam logic [32:0] RAM_SZ  = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [32:0] RAM_HI  = RAM_LO + RAM_SZ;
    localparam logic [32:0] MMIO_LO = {1'b0, MMIO_BASE};
    localparam logic [32:0] MMIO_HI = MMIO_LO + {1'b0, MMIO_SIZE};

    // Reject illegal configurations at elaboration
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
    end
    if ((RAM_LO & (RAM_SZ - 33'd1)) != 33'd0) begin : g_bad_align
        $error("dmem_responder: BASE_ADDR must be aligned to 4*DEPTH_WORDS");
    end
    if ((RAM_LO < MMIO_HI) && (MMIO_LO < RAM_HI)) begin : g_bad_overlap
        $error("dmem_responder: RAM range overlaps the MMIO window");
    end

    logic [32:0]   wa_ext;
    logic          in_range;
    logic          wr_active;
    logic          ram_we;
    logic          wr_err;
    logic [AW-1:0] idx;
    logic [31:0]   bank_rd;
    logic [31:0]   rd;
    logic          err_q,      err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    assign wa_ext    = {1'b0, bus.mem_d_wa};
    assign in_range  = (wa_ext >= RAM_LO) && (wa_ext < RAM_HI);
    assign idx       = bus.mem_d_wa[AW+1:2];
    assign wr_active = bus.mem_d_we && (bus.mem_d_wdbe != 4'b0000);
    // Holding reset suppresses the RAM write even though the RAM itself is not reset
    assign ram_we    = wr_active && in_range && !reset;

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .we_i  (ram_we),
        .be_i  (bus.mem_d_wdbe),
        .addr_i(idx),
        .wd_i  (bus.mem_d_wd),
        .rd_o  (bank_rd)
    );

`ifdef DMEM_MMIO_EN
    logic        mmio_hit;
    logic [3:0]  mmio_off;
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] mmio_rd;
    logic [31:0] wmask;

    assign mmio_hit = (bus.mem_d_wa[31:4] == MMIO_BASE[31:4]);
    assign mmio_off = {bus.mem_d_wa[3:2], 2'b00};
    assign wmask    = lane_mask(bus.mem_d_wdbe);
    // Every window address is writable; only tohost actually stores data
    assign wr_err   = wr_active && !in_range && !mmio_hit;
    assign cnt_d    = cnt_q + 64'd1;

    // tohost takes the enabled lanes of a write to its offset
    always_comb begin
        tohost_d = tohost_q;
        if (wr_active && mmio_hit && (mmio_off == MMIO_TOHOST[3:0])) begin
            tohost_d = (tohost_q & ~wmask) | (bus.mem_d_wd & wmask);
        end
    end

    // Free-running cycle counter and tohost register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 64'd0;
            tohost_q <= 32'd0;
        end else begin
            cnt_q    <= cnt_d;
            tohost_q <= tohost_d;
        end
    end

    // Select the MMIO word for the current offset; +0xC reads zero
    always_comb begin
        mmio_rd = 32'd0;
        if (mmio_off == MMIO_CNT_LO[3:0]) begin
            mmio_rd = cnt_q[31:0];
        end else if (mmio_off == MMIO_CNT_HI[3:0]) begin
            mmio_rd = cnt_q[63:32];
        end else if (mmio_off == MMIO_TOHOST[3:0]) begin
            mmio_rd = tohost_q;
        end
    end

    assign tohost = tohost_q;

    // RAM word when in range, else the MMIO word, else zero
    always_comb begin
        rd = 32'd0;
        if (in_range) begin
            rd = bank_rd;
        end else if (mmio_hit) begin
            rd = mmio_rd;
        end
    end
`else
    assign wr_err = wr_active && !in_range;

    // RAM word when in range, else zero
    always_comb begin
        rd = 32'd0;
        if (in_range) begin
            rd = bank_rd;
        end
    end
`endif

    assign bus.mem_d_rd = rd;

    // Capture only the first offending write address
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (wr_err && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = bus.mem_d_wa;
        end
    end

    // Sticky error state, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule
